// File: rtl/mux2_rr_arbiter.sv
// rtl/mux2_rr_arbiter.sv - round-robin grant controller in front of a shared 2:1 enabled mux
module mux2_rr_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             se,
  output logic             en,
  output logic [WIDTH-1:0] y,
  output logic             y_valid
);

  localparam int CW = $clog2(MAX_HOLD) + 1;
  localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            last_q, last_d;

  // State register; reset leaves B as last served so A wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      last_q     <= last_d;
    end
  end

  // Next-state: serve the waiting side on a tie, rotate when the hold cap is hit
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_a && req_b) state_d = last_q ? GRANT_B : GRANT_A;
        else if (req_a)     state_d = GRANT_A;
        else if (req_b)     state_d = GRANT_B;
      end
      GRANT_A: begin
        if (!req_a)                              state_d = req_b ? GRANT_B : IDLE;
        else if (req_b && hold_cnt_q == HOLD_LIM) state_d = GRANT_B;
      end
      GRANT_B: begin
        if (!req_b)                              state_d = req_a ? GRANT_A : IDLE;
        else if (req_a && hold_cnt_q == HOLD_LIM) state_d = GRANT_A;
      end
      default: state_d = IDLE;
    endcase
  end

  // Hold counter restarts on every state change and saturates while a lone owner keeps the grant
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    last_d     = last_q;
    if (state_d != state_q) begin
      hold_cnt_d = '0;
      if (state_d == GRANT_A)      last_d = 1'b1;
      else if (state_d == GRANT_B) last_d = 1'b0;
    end else if (state_q != IDLE && hold_cnt_q != HOLD_LIM) begin
      hold_cnt_d = hold_cnt_q + CW'(1);
    end
  end

  // Moore outputs decoded from the registered state; data path stays combinational
  always_comb begin
    gnt_a   = (state_q == GRANT_A);
    gnt_b   = (state_q == GRANT_B);
    se      = gnt_a;
    en      = gnt_a | gnt_b;
    y_valid = en;
    y       = en ? (se ? a : b) : '0;
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb/tb_mux2_rr_arbiter.sv - scoreboard bench for mux2_rr_arbiter
module tb_mux2_rr_arbiter;
  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         req_a, req_b;
  logic [W-1:0] a, b;
  logic         gnt_a, gnt_b, se, en, y_valid;
  logic [W-1:0] y;
  logic         gnt_a1, gnt_b1, se1, en1, y_valid1;
  logic [W-1:0] y1;

  int checks   = 0;
  int failures = 0;

  logic [W+4:0] exp_q[$];
  logic [W+4:0] expv;
  logic [W+4:0] obs, obs1;

  assign obs  = {gnt_a, gnt_b, se, en, y_valid, y};
  assign obs1 = {gnt_a1, gnt_b1, se1, en1, y_valid1, y1};

  mux2_rr_arbiter #(.WIDTH(W), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .se(se), .en(en), .y(y), .y_valid(y_valid)
  );

  mux2_rr_arbiter #(.WIDTH(W), .MAX_HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
    .gnt_a(gnt_a1), .gnt_b(gnt_b1), .se(se1), .en(en1), .y(y1), .y_valid(y_valid1)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus, queue the expected post-edge outputs, step past the edge
  task automatic drive(input logic r, input logic ra, input logic rb,
                       input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic ga, input logic gb);
    logic [W-1:0] ey;
    rst = r; req_a = ra; req_b = rb; a = av; b = bv;
    ey = ga ? av : (gb ? bv : '0);
    exp_q.push_back({ga, gb, ga, ga | gb, ga | gb, ey});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1, 4'hA, 4'h5, 1'b0, 1'b0);
      expv = exp_q.pop_front(); checks++;
      if (obs !== expv) begin failures++; $display("FAIL reset_hold cyc%0d got=%h exp=%h", i, obs, expv); end
    end
    drive(1'b0, 1'b1, 1'b1, 4'hA, 4'h5, 1'b1, 1'b0);
    expv = exp_q.pop_front(); checks++;
    if (obs !== expv) begin failures++; $display("FAIL reset_first_tie got=%h exp=%h", obs, expv); end
  endtask

  task automatic test_single;
    drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    expv = exp_q.pop_front(); checks++;
    if (obs !== expv) begin failures++; $display("FAIL single_rst got=%h exp=%h", obs, expv); end
    drive(1'b0, 1'b0, 1'b1, 4'hE, 4'h1, 1'b0, 1'b1);
    expv = exp_q.pop_front(); checks++;
    if (obs !== expv) begin failures++; $display("FAIL single_b_grant got=%h exp=%h", obs, expv); end
    drive(1'b0, 1'b0, 1'b1, 4'hE, 4'h7, 1'b0, 1'b1);
    expv = exp_q.pop_front(); checks++;
    if (obs !== expv) begin failures++; $display("FAIL single_b_data got=%h exp=%h", obs, expv); end
    drive(1'b0, 1'b0, 1'b0, 4'hE, 4'h7, 1'b0, 1'b0);
    expv = exp_q.pop_front(); checks++;
    if (obs !== expv) begin failures++; $display("FAIL single_release got=%h exp=%h", obs, expv); end
  endtask

  task automatic test_contention;
    logic [W-1:0] av;
    drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 16; i++) begin
      av = W'(i);
      drive(1'b0, 1'b1, 1'b1, av, ~av, ((i / 4) % 2) == 0, ((i / 4) % 2) == 1);
      expv = exp_q.pop_front(); checks++;
      if (obs !== expv) begin failures++; $display("FAIL contention cyc%0d got=%h exp=%h", i, obs, expv); end
    end
  endtask

  task automatic test_early_release;
    logic [1:0] pat_req[7];
    logic [1:0] pat_gnt[7];
    pat_req = '{2'b10, 2'b10, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11};
    pat_gnt = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, pat_req[i][1], pat_req[i][0], 4'h3, 4'hC, pat_gnt[i][1], pat_gnt[i][0]);
      expv = exp_q.pop_front(); checks++;
      if (obs !== expv) begin failures++; $display("FAIL early_release cyc%0d got=%h exp=%h", i, obs, expv); end
    end
  endtask

  task automatic test_saturation;
    drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 1'b0, 4'h9, 4'h6, 1'b1, 1'b0);
      expv = exp_q.pop_front(); checks++;
      if (obs !== expv) begin failures++; $display("FAIL saturation_hold cyc%0d got=%h exp=%h", i, obs, expv); end
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b1, 4'h9, 4'h6, i == 4, i != 4);
      expv = exp_q.pop_front(); checks++;
      if (obs !== expv) begin failures++; $display("FAIL saturation_takeover cyc%0d got=%h exp=%h", i, obs, expv); end
    end
  endtask

  task automatic test_mid_reset;
    drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b1, 4'hB, 4'h4, i < 4, i == 4);
      expv = exp_q.pop_front(); checks++;
      if (obs !== expv) begin failures++; $display("FAIL mid_reset_pre cyc%0d got=%h exp=%h", i, obs, expv); end
    end
    drive(1'b1, 1'b1, 1'b1, 4'hB, 4'h4, 1'b0, 1'b0);
    expv = exp_q.pop_front(); checks++;
    if (obs !== expv) begin failures++; $display("FAIL mid_reset_clear got=%h exp=%h", obs, expv); end
    drive(1'b0, 1'b1, 1'b1, 4'hB, 4'h4, 1'b1, 1'b0);
    expv = exp_q.pop_front(); checks++;
    if (obs !== expv) begin failures++; $display("FAIL mid_reset_tie_a got=%h exp=%h", obs, expv); end
  endtask

  task automatic test_max_hold_one;
    drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    expv = exp_q.pop_front(); checks++;
    if (obs1 !== expv) begin failures++; $display("FAIL hold1_reset got=%h exp=%h", obs1, expv); end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'b1, 4'h2, 4'hD, (i % 2) == 0, (i % 2) == 1);
      expv = exp_q.pop_front(); checks++;
      if (obs1 !== expv) begin failures++; $display("FAIL hold1_alternate cyc%0d got=%h exp=%h", i, obs1, expv); end
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; req_a = 1'b0; req_b = 1'b0; a = '0; b = '0;
    @(posedge clk);
    #1;
    test_reset;
    test_single;
    test_contention;
    test_early_release;
    test_saturation;
    test_mid_reset;
    test_max_hold_one;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
